// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared ALU codes, M-extension widths and sequencer state type
package riscv_pkg;

    localparam int MD_WIDTH = 32;

    localparam logic [3:0] ALU_MUL = 4'b0011;
    localparam logic [3:0] ALU_DIV = 4'b0100;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_MUL  = 2'd1,
        MD_DIV  = 2'd2,
        MD_DONE = 2'd3
    } md_state_t;

endpackage

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one radix-2 iteration of shift-add multiply or restoring divide
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             op_div_i,
    input  logic [WIDTH:0]   hi_i,
    input  logic [WIDTH-1:0] lo_i,
    input  logic [WIDTH-1:0] opnd_i,
    output logic [WIDTH:0]   hi_o,
    output logic [WIDTH-1:0] lo_o
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] diff;

    // MUL: {acc, mplier} conditionally add multiplicand then shift right.
    // DIV: {rem, quo} shift left, trial subtract, restore when negative.
    always_comb begin
        sum    = hi_i + (lo_i[0] ? {1'b0, opnd_i} : '0);
        rem_sh = {hi_i[WIDTH-1:0], lo_i[WIDTH-1]};
        diff   = rem_sh - {1'b0, opnd_i};
        if (op_div_i) begin
            if (diff[WIDTH]) begin
                hi_o = rem_sh;
                lo_o = {lo_i[WIDTH-2:0], 1'b0};
            end else begin
                hi_o = diff;
                lo_o = {lo_i[WIDTH-2:0], 1'b1};
            end
        end else begin
            hi_o = {1'b0, sum[WIDTH:1]};
            lo_o = {sum[0], lo_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - multi-cycle MUL/DIV controller stalling the EX stage
module muldiv_sequencer
    import riscv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [3:0]       alu_ctrl_i,
    input  logic [WIDTH-1:0] op_a_i,
    input  logic [WIDTH-1:0] op_b_i,
    input  logic [4:0]       rd_i,
    input  logic             flush_i,
    output logic             stall_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic [4:0]       rd_o
);

    localparam logic [WIDTH-1:0] INT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    md_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH:0]   hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic             neg_q, neg_d;
    logic [4:0]       rd_q, rd_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [4:0]       rdo_q, rdo_d;

    logic             is_md;
    logic             accept;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic [WIDTH:0]   step_hi;
    logic [WIDTH-1:0] step_lo;

    assign is_md = (alu_ctrl_i == ALU_MUL) || (alu_ctrl_i == ALU_DIV);
    assign abs_a = op_a_i[WIDTH-1] ? -op_a_i : op_a_i;
    assign abs_b = op_b_i[WIDTH-1] ? -op_b_i : op_b_i;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .op_div_i (state_q == MD_DIV),
        .hi_i     (hi_q),
        .lo_i     (lo_q),
        .opnd_i   (opnd_q),
        .hi_o     (step_hi),
        .lo_o     (step_lo)
    );

    // Next-state, datapath updates and stall; flush beats accept and iteration.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        opnd_d  = opnd_q;
        neg_d   = neg_q;
        rd_d    = rd_q;
        res_d   = res_q;
        rdo_d   = rdo_q;
        accept  = 1'b0;
        stall_o = 1'b0;
        case (state_q)
            MD_IDLE: begin
                accept  = start_i & is_md & ~flush_i;
                stall_o = accept;
                if (accept) begin
                    rd_d  = rd_i;
                    cnt_d = CNT_W'(WIDTH - 1);
                    hi_d  = '0;
                    if (alu_ctrl_i == ALU_MUL) begin
                        lo_d    = op_b_i;
                        opnd_d  = op_a_i;
                        neg_d   = 1'b0;
                        state_d = MD_MUL;
                    end else if (op_b_i == '0) begin
                        res_d   = '1;
                        rdo_d   = rd_i;
                        state_d = MD_DONE;
                    end else if (op_a_i == INT_MIN && op_b_i == '1) begin
                        res_d   = INT_MIN;
                        rdo_d   = rd_i;
                        state_d = MD_DONE;
                    end else begin
                        lo_d    = abs_a;
                        opnd_d  = abs_b;
                        neg_d   = op_a_i[WIDTH-1] ^ op_b_i[WIDTH-1];
                        state_d = MD_DIV;
                    end
                end
            end
            MD_MUL, MD_DIV: begin
                if (flush_i) begin
                    state_d = MD_IDLE;
                end else begin
                    stall_o = 1'b1;
                    hi_d    = step_hi;
                    lo_d    = step_lo;
                    cnt_d   = cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        cnt_d   = '0;
                        state_d = MD_DONE;
                        rdo_d   = rd_q;
                        res_d   = (state_q == MD_DIV && neg_q) ? -step_lo : step_lo;
                    end
                end
            end
            MD_DONE: state_d = MD_IDLE;
            default: state_d = MD_IDLE;
        endcase
    end

    // State and datapath registers; reset discards any partial result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            opnd_q  <= '0;
            neg_q   <= 1'b0;
            rd_q    <= '0;
            res_q   <= '0;
            rdo_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            opnd_q  <= opnd_d;
            neg_q   <= neg_d;
            rd_q    <= rd_d;
            res_q   <= res_d;
            rdo_q   <= rdo_d;
        end
    end

    assign busy_o   = (state_q != MD_IDLE);
    assign done_o   = (state_q == MD_DONE);
    assign result_o = res_q;
    assign rd_o     = rdo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - directed bench with cycle-level reference model
module tb_muldiv_sequencer;

    localparam logic [3:0] C_MUL = 4'b0011;
    localparam logic [3:0] C_DIV = 4'b0100;
    localparam logic [3:0] C_ADD = 4'b0010;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  alu = 4'b0000;
    logic [31:0] opa = '0;
    logic [31:0] opb = '0;
    logic [4:0]  rdi = '0;
    logic        flush = 1'b0;
    logic        stall_o, busy_o, done_o;
    logic [31:0] result_o;
    logic [4:0]  rd_o;

    int checks = 0;
    int errors = 0;

    muldiv_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start),
        .alu_ctrl_i (alu),
        .op_a_i     (opa),
        .op_b_i     (opb),
        .rd_i       (rdi),
        .flush_i    (flush),
        .stall_o    (stall_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .result_o   (result_o),
        .rd_o       (rd_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_m(input logic [3:0] c);
        return (c == C_MUL) || (c == C_DIV);
    endfunction

    function automatic bit is_special(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        return (c == C_DIV) && ((b == 32'd0) || (a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    function automatic logic [31:0] model_result(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        if (c == C_MUL) begin
            r = a * b;
        end else if (b == 32'd0) begin
            r = 32'hFFFF_FFFF;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            r = 32'h8000_0000;
        end else begin
            r = $signed(a) / $signed(b);
        end
        return r;
    endfunction

    // Abstract model: cycles left in the busy phase, a done flag, and held outputs.
    int          m_busy = 0;
    bit          m_done = 1'b0;
    logic [31:0] m_res = '0;
    logic [4:0]  m_rd = '0;
    logic [31:0] p_res = '0;
    logic [4:0]  p_rd = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 0;
            m_done = 1'b0;
            m_res  = '0;
            m_rd   = '0;
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (m_busy > 0) begin
            if (flush) begin
                m_busy = 0;
            end else begin
                m_busy = m_busy - 1;
                if (m_busy == 0) begin
                    m_done = 1'b1;
                    m_res  = p_res;
                    m_rd   = p_rd;
                end
            end
        end else if (start && is_m(alu) && !flush) begin
            if (is_special(alu, opa, opb)) begin
                m_done = 1'b1;
                m_res  = model_result(alu, opa, opb);
                m_rd   = rdi;
            end else begin
                m_busy = 32;
                p_res  = model_result(alu, opa, opb);
                p_rd   = rdi;
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("stall", {31'd0, stall_o},
                {31'd0, (m_busy > 0 && !flush) || (m_busy == 0 && !m_done && start && is_m(alu) && !flush)});
            chk("busy", {31'd0, busy_o}, {31'd0, (m_busy > 0) || m_done});
            chk("done", {31'd0, done_o}, {31'd0, m_done});
            chk("result", result_o, m_res);
            chk("rd", {27'd0, rd_o}, {27'd0, m_rd});
        end
    end

    // Issue one op, then measure latency, stall cycles and final outputs.
    task automatic run_op(input string name, input logic [3:0] c, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd,
                          input logic [31:0] exp_res, input int exp_lat);
        int lat;
        int stalls;
        bit got;
        @(posedge clk); #1;
        start = 1'b1; alu = c; opa = a; opb = b; rdi = rd;
        lat = 0; stalls = 0; got = 1'b0;
        while (lat <= 40 && !got) begin
            @(negedge clk);
            if (stall_o) stalls++;
            if (done_o) begin
                got = 1'b1;
            end else begin
                @(posedge clk); #1;
                start = 1'b0;
                lat++;
            end
        end
        start = 1'b0;
        if (!got) begin
            chk({name, "_timeout"}, 32'd0, 32'd1);
        end else begin
            chk({name, "_res"}, result_o, exp_res);
            chk({name, "_rd"}, {27'd0, rd_o}, {27'd0, rd});
            chk({name, "_lat"}, lat, exp_lat);
            chk({name, "_stalls"}, stalls, (exp_lat == 1) ? 1 : 33);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_stall", {31'd0, stall_o}, 32'd0);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_done", {31'd0, done_o}, 32'd0);
        chk("rst_result", result_o, 32'd0);
        rst_n = 1'b1;

        chk("model_mul", model_result(C_MUL, 32'd7, 32'd6), 32'd42);
        chk("model_div", model_result(C_DIV, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);

        run_op("mul_7x6",   C_MUL, 32'd7,          32'd6,          5'd5,  32'd42,          33);
        run_op("mul_ffxff", C_MUL, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd9,  32'd1,           33);
        run_op("mul_m3x5",  C_MUL, 32'hFFFF_FFFD,  32'd5,          5'd12, 32'hFFFF_FFF1,   33);
        run_op("div_m7_2",  C_DIV, 32'hFFFF_FFF9,  32'd2,          5'd3,  32'hFFFF_FFFD,   33);
        run_op("div_100_m7", C_DIV, 32'd100,       32'hFFFF_FFF9,  5'd17, 32'hFFFF_FFF2,   33);
        run_op("div_by0",   C_DIV, 32'd12345,      32'd0,          5'd21, 32'hFFFF_FFFF,   1);
        run_op("div_ovf",   C_DIV, 32'h8000_0000,  32'hFFFF_FFFF,  5'd30, 32'h8000_0000,   1);
        run_op("div_min_2", C_DIV, 32'h8000_0000,  32'd2,          5'd7,  32'hC000_0000,   33);

        // accept blocked when flush coincides with start in IDLE
        @(posedge clk); #1;
        start = 1'b1; alu = C_MUL; opa = 32'd3; opb = 32'd3; rdi = 5'd1; flush = 1'b1;
        @(negedge clk);
        chk("flush_blk_stall", {31'd0, stall_o}, 32'd0);
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        @(negedge clk);
        chk("flush_blk_busy", {31'd0, busy_o}, 32'd0);

        // flush at iteration 10, with start held (ignored) while busy
        @(posedge clk); #1;
        start = 1'b1; alu = C_MUL; opa = 32'd123; opb = 32'd456; rdi = 5'd11;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk); #1;
            if (i < 10) begin
                alu = C_DIV; opb = 32'd0;
            end else begin
                start = 1'b0; flush = 1'b1;
            end
        end
        @(negedge clk);
        chk("flush_stall", {31'd0, stall_o}, 32'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        chk("flush_busy", {31'd0, busy_o}, 32'd0);
        chk("flush_done", {31'd0, done_o}, 32'd0);
        run_op("mul_2x3", C_MUL, 32'd2, 32'd3, 5'd4, 32'd6, 33);

        // reset mid-DIV clears everything immediately
        @(posedge clk); #1;
        start = 1'b1; alu = C_DIV; opa = 32'd1000; opb = 32'd3; rdi = 5'd19;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstmid_stall", {31'd0, stall_o}, 32'd0);
        chk("rstmid_busy", {31'd0, busy_o}, 32'd0);
        chk("rstmid_done", {31'd0, done_o}, 32'd0);
        chk("rstmid_result", result_o, 32'd0);
        chk("rstmid_rd", {27'd0, rd_o}, 32'd0);
        @(posedge clk); #3;
        rst_n = 1'b1;

        // non-M code never stalls nor goes busy
        @(posedge clk); #1;
        start = 1'b1; alu = C_ADD; opa = 32'd5; opb = 32'd6; rdi = 5'd2;
        @(negedge clk);
        chk("add_stall", {31'd0, stall_o}, 32'd0);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("add_busy", {31'd0, busy_o}, 32'd0);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
